systolic_feature_skewer: RTL

//  Upstream feeder for the systolic vector array. Accepts one ROW-wide feature

---
 rtl/systolic_feature_skewer_pkg.sv | 14 +
 rtl/systolic_feature_skewer_lane.sv | 37 +++
 rtl/systolic_feature_skewer.sv | 110 +++++++++++
 3 files changed

// File: rtl/systolic_feature_skewer_pkg.sv
// Shared types and defaults for the systolic feature skewer.
package sys_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } skew_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ROW   = 32;
  localparam int DEF_LEN_W = 16;

endpackage

// File: rtl/systolic_feature_skewer_lane.sv
// One skew lane: DEPTH-stage {en, data} shift register with output gating.
module skew_lane #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_en,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] en_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      en_q[0]   <= in_en;
      data_q[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        en_q[i]   <= en_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // A disabled lane must never leak stale data into the array.
  assign out_en   = en_q[DEPTH-1];
  assign out_data = en_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/systolic_feature_skewer.sv
// Diagonal feature skewer: accepts ROW-wide vectors and delays lane i by i
// cycles, sequencing one tile of cfg_len vectors through stream and drain.
module systolic_feature_skewer
  import sys_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROW   = DEF_ROW,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data [ROW],
  output logic [WIDTH-1:0] feat_out [ROW],
  output logic [ROW-1:0]   feat_en,
  output logic             busy,
  output logic             tile_done
);

  localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(ROW - 2);

  skew_state_t      state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_last;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] dcnt;
  logic             accept;
  logic [WIDTH-1:0] stage0_data [ROW];

  assign accept   = s_valid & s_ready;
  assign len_last = len_q - LEN_W'(1);

  // Bubbles carry zero data so idle stages stay clean.
  always_comb begin
    for (int unsigned i = 0; i < ROW; i++) begin
      stage0_data[i] = accept ? s_data[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      dcnt      <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_len != '0) begin
              state   <= STREAM;
              len_q   <= cfg_len;
              cnt     <= '0;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end else begin
              tile_done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_last) begin
              state   <= DRAIN;
              dcnt    <= '0;
              s_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          dcnt <= dcnt + LEN_W'(1);
          // Last vector reaches lane ROW-1 on this edge.
          if (dcnt == DRAIN_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            tile_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < ROW; g++) begin : g_lane
    skew_lane #(
      .WIDTH(WIDTH),
      .DEPTH(g + 1)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .in_en   (accept),
      .in_data (stage0_data[g]),
      .out_en  (feat_en[g]),
      .out_data(feat_out[g])
    );
  end

endmodule
